// File: rtl/uart_com.sv
// 8N1 UART for the memory controller's COM port: independent TX and RX FSMs,
// with a one-deep receive buffer and overrun/framing status flags.
module uart_com #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk50M,
  input  logic       rst,
  input  logic       rxd,
  output logic       txd,
  input  logic [7:0] com_data_out,
  input  logic       enable_com_write,
  output logic       com_write_ready,
  output logic [7:0] com_data_in,
  output logic       com_read_ready,
  input  logic       int_com_ack,
  output logic       com_overrun,
  output logic       com_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  tx_state_t        tx_state_reg, tx_state_next;
  logic [CNT_W-1:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0]       tx_bit_reg, tx_bit_next;
  logic [7:0]       tx_shift_reg, tx_shift_next;
  logic             txd_reg, txd_next;
  logic             ready_reg;

  rx_state_t        rx_state_reg, rx_state_next;
  logic [CNT_W-1:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0]       rx_bit_reg, rx_bit_next;
  logic [7:0]       rx_shift_reg, rx_shift_next;
  logic             rx_meta_reg, rxs_reg;
  logic             rx_done, rx_bad;
  logic [7:0]       data_reg;
  logic             read_ready_reg, overrun_reg, frame_err_reg;

  // txd and com_write_ready are registered so the line never glitches
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      txd_reg      <= 1'b1;
      ready_reg    <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      txd_reg      <= txd_next;
      ready_reg    <= (tx_state_next == TX_IDLE);
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    txd_next      = 1'b1;
    case (tx_state_reg)
      TX_IDLE: begin
        if (enable_com_write) begin
          tx_shift_next = com_data_out;
          tx_cnt_next   = '0;
          tx_bit_next   = '0;
          tx_state_next = TX_START;
          txd_next      = 1'b0;
        end
      end
      TX_START: begin
        txd_next = 1'b0;
        if (tx_cnt_reg == LAST) begin
          tx_cnt_next   = '0;
          tx_state_next = TX_DATA;
          txd_next      = tx_shift_reg[0];
        end else begin
          tx_cnt_next = tx_cnt_reg + 1'b1;
        end
      end
      TX_DATA: begin
        txd_next = tx_shift_reg[0];
        if (tx_cnt_reg == LAST) begin
          tx_cnt_next   = '0;
          tx_shift_next = {1'b0, tx_shift_reg[7:1]};
          tx_bit_next   = tx_bit_reg + 3'd1;
          txd_next      = tx_shift_reg[1];
          if (tx_bit_reg == 3'd7) begin
            tx_state_next = TX_STOP;
            txd_next      = 1'b1;
          end
        end else begin
          tx_cnt_next = tx_cnt_reg + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_reg == LAST) begin
          tx_cnt_next   = '0;
          tx_state_next = TX_IDLE;
        end else begin
          tx_cnt_next = tx_cnt_reg + 1'b1;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      rx_meta_reg    <= 1'b1;
      rxs_reg        <= 1'b1;
      rx_state_reg   <= RX_IDLE;
      rx_cnt_reg     <= '0;
      rx_bit_reg     <= '0;
      rx_shift_reg   <= '0;
      data_reg       <= '0;
      read_ready_reg <= 1'b0;
      overrun_reg    <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      rx_meta_reg   <= rxd;
      rxs_reg       <= rx_meta_reg;
      rx_state_reg  <= rx_state_next;
      rx_cnt_reg    <= rx_cnt_next;
      rx_bit_reg    <= rx_bit_next;
      rx_shift_reg  <= rx_shift_next;
      frame_err_reg <= rx_bad;
      // a completing byte beats a concurrent ack; overrun only when unacked
      if (rx_done) begin
        data_reg       <= rx_shift_reg;
        read_ready_reg <= 1'b1;
        overrun_reg    <= int_com_ack ? 1'b0 : (overrun_reg | read_ready_reg);
      end else if (int_com_ack) begin
        read_ready_reg <= 1'b0;
        overrun_reg    <= 1'b0;
      end
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_done       = 1'b0;
    rx_bad        = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        // the cycle that sees the low level counts as the first start-bit cycle
        if (!rxs_reg) begin
          rx_cnt_next   = CNT_W'(1);
          rx_state_next = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_reg == HALF) begin
          rx_cnt_next   = '0;
          rx_bit_next   = '0;
          rx_state_next = rxs_reg ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_reg == LAST) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rxs_reg, rx_shift_reg[7:1]};
          rx_bit_next   = rx_bit_reg + 3'd1;
          if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_reg == LAST) begin
          rx_cnt_next   = '0;
          rx_done       = rxs_reg;
          rx_bad        = !rxs_reg;
          rx_state_next = rxs_reg ? RX_IDLE : RX_BREAK;
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      RX_BREAK: begin
        if (rxs_reg) rx_state_next = RX_IDLE;
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  assign txd             = txd_reg;
  assign com_write_ready = ready_reg;
  assign com_data_in     = data_reg;
  assign com_read_ready  = read_ready_reg;
  assign com_overrun     = overrun_reg;
  assign com_frame_err   = frame_err_reg;

endmodule

// File: tb/tb_uart_com.sv
// Bench for uart_com at 16 clocks per bit: randomized TX/RX bytes checked
// against a frame-level model of the line and the receive buffer.
module tb_uart_com;
  localparam int CPB = 16;

  logic       clk50M = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       txd;
  logic [7:0] com_data_out = 8'h00;
  logic       enable_com_write = 1'b0;
  logic       com_write_ready;
  logic [7:0] com_data_in;
  logic       com_read_ready;
  logic       int_com_ack = 1'b0;
  logic       com_overrun;
  logic       com_frame_err;

  int tests = 0;
  int fails = 0;
  int fe_count = 0;

  logic [7:0] exp_data = 8'h00;
  logic       exp_ready = 1'b0;
  logic       exp_overrun = 1'b0;

  uart_com #(.CLKS_PER_BIT(CPB)) dut (
    .clk50M(clk50M), .rst(rst), .rxd(rxd), .txd(txd),
    .com_data_out(com_data_out), .enable_com_write(enable_com_write),
    .com_write_ready(com_write_ready), .com_data_in(com_data_in),
    .com_read_ready(com_read_ready), .int_com_ack(int_com_ack),
    .com_overrun(com_overrun), .com_frame_err(com_frame_err)
  );

  always #10 clk50M = ~clk50M;

  always @(negedge clk50M) if (com_frame_err === 1'b1) fe_count++;

  task automatic idle(input int n);
    repeat (n) @(negedge clk50M);
  endtask

  // Buffer model: a good frame fills the buffer, overrunning an unread byte.
  task automatic model_byte(input logic [7:0] b);
    if (exp_ready) exp_overrun = 1'b1;
    exp_data  = b;
    exp_ready = 1'b1;
  endtask

  task automatic model_ack();
    exp_ready   = 1'b0;
    exp_overrun = 1'b0;
  endtask

  // Drive an 8N1 frame on rxd; a bad stop bit can be stretched into a break.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int extra_low);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = frame[i];
      repeat (CPB) @(negedge clk50M);
    end
    if (!stop) repeat (extra_low) @(negedge clk50M);
    rxd = 1'b1;
  endtask

  task automatic ack(input int n);
    int_com_ack = 1'b1;
    repeat (n) @(negedge clk50M);
    int_com_ack = 1'b0;
    model_ack();
    idle(1);
  endtask

  task automatic test_reset();
    tests++; if (txd !== 1'b1) begin fails++; $display("FAIL reset_txd got %b want 1", txd); end
    tests++; if (com_write_ready !== 1'b1) begin fails++; $display("FAIL reset_wr_ready got %b want 1", com_write_ready); end
    tests++; if (com_data_in !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", com_data_in); end
    tests++; if (com_read_ready !== 1'b0) begin fails++; $display("FAIL reset_rd_ready got %b want 0", com_read_ready); end
    tests++; if (com_overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b want 0", com_overrun); end
    tests++; if (com_frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err got %b want 0", com_frame_err); end
    $display("[TB] reset checked");
  endtask

  // Transmit one byte; optionally fire a second write mid-frame which must be ignored.
  task automatic test_tx(input logic [7:0] b, input int busy_at, input logic [7:0] busy_byte);
    logic [9:0] frame;
    logic [9:0] bad;
    int low;
    int extra;
    frame = {1'b1, b, 1'b0};
    bad = '0;
    low = 0;
    com_data_out = b;
    enable_com_write = 1'b1;
    @(negedge clk50M);
    enable_com_write = 1'b0;
    com_data_out = 8'h00;
    for (int i = 0; i < 10 * CPB; i++) begin
      if (txd !== frame[i / CPB]) bad[i / CPB] = 1'b1;
      if (com_write_ready !== 1'b1) low++;
      enable_com_write = (i == busy_at);
      com_data_out = (i == busy_at) ? busy_byte : 8'h00;
      @(negedge clk50M);
    end
    enable_com_write = 1'b0;
    while (com_write_ready !== 1'b1 && low < 400) begin
      low++;
      @(negedge clk50M);
    end
    for (int k = 0; k < 10; k++) begin
      tests++;
      if (bad[k]) begin
        fails++; $display("FAIL tx_bit%0d byte %h got wrong level want %b", k, b, frame[k]);
      end
    end
    tests++; if (low != 10 * CPB) begin fails++; $display("FAIL tx_ready_low byte %h got %0d cycles want %0d", b, low, 10 * CPB); end
    extra = 0;
    for (int i = 0; i < 200; i++) begin
      if (txd !== 1'b1 || com_write_ready !== 1'b1) extra++;
      @(negedge clk50M);
    end
    tests++; if (extra != 0) begin fails++; $display("FAIL tx_idle_after byte %h got %0d busy cycles want 0", b, extra); end
    $display("[TB] tx byte %h busy_at %0d checked", b, busy_at);
  endtask

  task automatic test_rx_byte(input logic [7:0] b);
    int fe0;
    fe0 = fe_count;
    send_frame(b, 1'b1, 0);
    model_byte(b);
    idle(4);
    tests++; if (com_data_in !== exp_data) begin fails++; $display("FAIL rx_data got %h want %h", com_data_in, exp_data); end
    tests++; if (com_read_ready !== exp_ready) begin fails++; $display("FAIL rx_ready got %b want %b", com_read_ready, exp_ready); end
    tests++; if (com_overrun !== exp_overrun) begin fails++; $display("FAIL rx_overrun got %b want %b", com_overrun, exp_overrun); end
    tests++; if (fe_count != fe0) begin fails++; $display("FAIL rx_no_frame_err got %0d pulses want 0", fe_count - fe0); end
    $display("[TB] rx byte %h data %h ready %b overrun %b", b, com_data_in, com_read_ready, com_overrun);
  endtask

  task automatic test_rx_ack();
    test_rx_byte(8'hA3);
    ack(3);
    tests++; if (com_read_ready !== 1'b0) begin fails++; $display("FAIL ack_ready got %b want 0", com_read_ready); end
    tests++; if (com_data_in !== 8'hA3) begin fails++; $display("FAIL ack_data got %h want a3", com_data_in); end
    $display("[TB] ack after a3 checked");
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_count;
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    idle(40);
    tests++; if (com_read_ready !== 1'b0) begin fails++; $display("FAIL glitch_ready got %b want 0", com_read_ready); end
    tests++; if (com_data_in !== exp_data || fe_count != fe0) begin
      fails++; $display("FAIL glitch_state got data %h fe %0d want data %h fe 0", com_data_in, fe_count - fe0, exp_data);
    end
    $display("[TB] glitch checked");
    test_rx_byte(8'h3C);
    ack(1);
  endtask

  task automatic test_frame_err();
    int fe0;
    fe0 = fe_count;
    send_frame(8'h12, 1'b0, 40);
    idle(20);
    tests++; if (fe_count - fe0 != 1) begin fails++; $display("FAIL frame_err_cycles got %0d want 1", fe_count - fe0); end
    tests++; if (com_read_ready !== 1'b0 || com_data_in !== exp_data) begin
      fails++; $display("FAIL frame_err_buffer got ready %b data %h want 0 %h", com_read_ready, com_data_in, exp_data);
    end
    $display("[TB] framing error checked");
    test_rx_byte(8'h7E);
    ack(1);
  endtask

  task automatic test_overrun();
    test_rx_byte(8'h11);
    test_rx_byte(8'h22);
    ack(1);
    tests++; if (com_read_ready !== 1'b0 || com_overrun !== 1'b0) begin
      fails++; $display("FAIL overrun_clear got ready %b overrun %b want 0 0", com_read_ready, com_overrun);
    end
    $display("[TB] overrun clear checked");
  endtask

  task automatic test_random_rx();
    for (int n = 0; n < 6; n++) begin
      test_rx_byte(8'($urandom));
      if ($urandom_range(0, 1) == 1) ack($urandom_range(1, 3));
    end
    if (exp_ready) ack(1);
  endtask

  task automatic test_reset_midframe();
    com_data_out = 8'h00;
    enable_com_write = 1'b1;
    rxd = 1'b0;
    @(negedge clk50M);
    enable_com_write = 1'b0;
    idle(40);
    #3 rst = 1'b1;
    #1;
    tests++; if (txd !== 1'b1) begin fails++; $display("FAIL rst_mid_txd got %b want 1", txd); end
    tests++; if (com_write_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_wr_ready got %b want 1", com_write_ready); end
    idle(3);
    rxd = 1'b1;
    rst = 1'b0;
    exp_data = 8'h00; exp_ready = 1'b0; exp_overrun = 1'b0;
    idle(200);
    tests++; if (com_read_ready !== 1'b0 || com_data_in !== 8'h00 || txd !== 1'b1) begin
      fails++; $display("FAIL rst_mid_after got ready %b data %h txd %b want 0 00 1", com_read_ready, com_data_in, txd);
    end
    $display("[TB] mid-frame reset checked");
  endtask

  initial begin
    idle(5);
    rst = 1'b0;
    idle(2);
    test_reset();
    test_tx(8'h55, -1, 8'h00);
    test_tx(8'h0F, 50, 8'hFF);
    for (int n = 0; n < 3; n++) test_tx(8'($urandom), -1, 8'h00);
    test_rx_ack();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_random_rx();
    test_reset_midframe();
    test_rx_byte(8'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
